nav_sequencer: RTL

NAV_SEQUENCER -- requirements
Module: nav_sequencer

---
 rtl/nav_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/nav_sequencer.sv
// Obstacle-avoidance sequencer: drives forward until a debounced obstacle is seen,
// then halts, turns (alternating direction) and retries up to MAX_RETRY times before faulting.
module nav_sequencer #(
  parameter int DEBOUNCE    = 4,
  parameter int STOP_CYCLES = 1000,
  parameter int TURN_CYCLES = 50000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       obstacle,
  output logic       forward,
  output logic       turnLeft,
  output logic       turnRight,
  output logic       tooClose,
  output logic       fault,
  output logic [2:0] state
);

  localparam int TMAX = (STOP_CYCLES > TURN_CYCLES) ? STOP_CYCLES : TURN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);
  localparam int DW   = $clog2(DEBOUNCE + 1);

  localparam logic [TW-1:0] STOP_LAST  = TW'(STOP_CYCLES - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_STOP  = 3'd2,
    S_TURN  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  logic [1:0]    sync_q;
  logic          obs_s;
  logic [DW-1:0] db_cnt_q;
  logic          obs_db_q;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          dir_q, dir_d;

  assign obs_s = sync_q[1];
  assign state = state_q;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      obs_db_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], obstacle};
      if (!obs_s) begin
        db_cnt_q <= '0;
        obs_db_q <= 1'b0;
      end else if (db_cnt_q == DB_LAST) begin
        obs_db_q <= 1'b1;
      end else begin
        db_cnt_q <= db_cnt_q + DW'(1);
      end
    end
  end

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    dir_d   = dir_q;
    if (!enable) begin
      state_d = S_IDLE;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d = '0;
          state_d = obs_db_q ? S_STOP : S_FWD;
        end
        S_FWD: begin
          timer_d = '0;
          if (obs_db_q) state_d = S_STOP;
        end
        S_STOP: begin
          if (timer_q == STOP_LAST) begin
            state_d = S_TURN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_TURN: begin
          if (timer_q == TURN_LAST) begin
            timer_d = '0;
            if (!obs_db_q) begin
              state_d = S_FWD;
              dir_d   = ~dir_q;
              retry_d = '0;
            end else begin
              retry_d = retry_q + RW'(1);
              state_d = (retry_q == RETRY_LAST) ? S_FAULT : S_STOP;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_FAULT: timer_d = '0;
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      retry_q   <= '0;
      dir_q     <= 1'b0;
      forward   <= 1'b0;
      turnLeft  <= 1'b0;
      turnRight <= 1'b0;
      tooClose  <= 1'b1;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      dir_q     <= dir_d;
      forward   <= (state_d == S_FWD);
      turnLeft  <= (state_d == S_TURN) && !dir_d;
      turnRight <= (state_d == S_TURN) && dir_d;
      tooClose  <= (state_d == S_IDLE) || (state_d == S_STOP) || (state_d == S_FAULT);
      fault     <= (state_d == S_FAULT);
    end
  end

endmodule
